// File: rtl/scroll_shifter.sv
// Scrolling digit-message shifter: rotates or fill-shifts a multi-digit message one digit per prescaled enable tick.
// Latency: a step appears on out (with step/wrap pulses) one clk after the tick; load takes effect in one clk.
// Backpressure: none; en freezes the prescaler and message, and load overrides any pending tick.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   en              scroll enable (gates the prescaler)
//   dir             0 = shift right (toward digit 0), 1 = shift left
//   mode            0 = rotate, 1 = insert fill digit
//   fill            digit inserted in fill mode
//   load, load_data synchronous message load
//   out             low DIGITS digits of the message register
//   pos             net scroll offset, 0..MSG_DIGITS-1
//   step, wrap      registered one-cycle pulses after a step / when that step lands pos on 0
module scroll_shifter #(
  parameter int DIGIT_W    = 4,
  parameter int DIGITS     = 8,
  parameter int MSG_DIGITS = 24,
  parameter int DIV        = 1,
  parameter logic [MSG_DIGITS*DIGIT_W-1:0] INIT = 96'hffffffff20119127ffffffff
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              dir,
  input  logic                              mode,
  input  logic [DIGIT_W-1:0]                fill,
  input  logic                              load,
  input  logic [MSG_DIGITS*DIGIT_W-1:0]     load_data,
  output logic [DIGITS*DIGIT_W-1:0]         out,
  output logic [$clog2(MSG_DIGITS)-1:0]     pos,
  output logic                              step,
  output logic                              wrap
);

  localparam int MSG_W = MSG_DIGITS * DIGIT_W;
  localparam int POS_W = $clog2(MSG_DIGITS);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MSG_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [MSG_W-1:0]   r_msg;
  logic [CNT_W-1:0]   r_cnt;
  logic [POS_W-1:0]   r_pos;
  logic               r_step;
  logic               r_wrap;

  logic               w_tick;
  logic [DIGIT_W-1:0] w_in_right;
  logic [DIGIT_W-1:0] w_in_left;
  logic [MSG_W-1:0]   w_msg_nxt;
  logic [POS_W-1:0]   w_pos_nxt;

  // Prescaler terminal count; a disabled cycle never ticks.
  assign w_tick = en && (r_cnt == CNT_MAX);

  // Digit entering at the vacated end: the digit falling off the other end, or fill.
  assign w_in_right = mode ? fill : r_msg[DIGIT_W-1:0];
  assign w_in_left  = mode ? fill : r_msg[MSG_W-1 -: DIGIT_W];

  // Next message/offset for a step. dir/mode/fill only matter when w_tick commits these.
  always_comb begin
    w_msg_nxt = r_msg;
    w_pos_nxt = r_pos;
    if (!dir) begin
      w_msg_nxt = {w_in_right, r_msg[MSG_W-1:DIGIT_W]};
      w_pos_nxt = (r_pos == POS_MAX) ? '0 : r_pos + POS_W'(1);
    end else begin
      w_msg_nxt = {r_msg[MSG_W-DIGIT_W-1:0], w_in_left};
      w_pos_nxt = (r_pos == '0) ? POS_MAX : r_pos - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg  <= INIT;
      r_cnt  <= '0;
      r_pos  <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else if (load) begin
      // Load wins over a coincident tick and restarts the prescaler.
      r_msg  <= load_data;
      r_cnt  <= '0;
      r_pos  <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (en) begin
        r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_tick) begin
        r_msg <= w_msg_nxt;
        r_pos <= w_pos_nxt;
      end
      // Pulses line up with the first cycle the shifted message is visible.
      r_step <= w_tick;
      r_wrap <= w_tick && (w_pos_nxt == '0);
    end
  end

  assign out  = r_msg[DIGITS*DIGIT_W-1:0];
  assign pos  = r_pos;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_scroll_shifter.sv
module tb_scroll_shifter;

  localparam int N = 24;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dir;
  logic        mode;
  logic [3:0]  fill;
  logic        load;
  logic [95:0] load_data;

  logic [31:0] out0, out1;
  logic [4:0]  pos0, pos1;
  logic        step0, step1, wrap0, wrap1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: message as an array of digits, offset/prescaler as plain integers.
  logic [3:0] m_msg [2][N];
  int         m_pos [2];
  int         m_cnt [2];
  bit         m_step[2];
  bit         m_wrap[2];
  int         div_of[2];

  scroll_shifter u_dut_div1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .fill(fill),
    .load(load), .load_data(load_data),
    .out(out0), .pos(pos0), .step(step0), .wrap(wrap0)
  );

  scroll_shifter #(.DIV(4)) u_dut_div4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .fill(fill),
    .load(load), .load_data(load_data),
    .out(out1), .pos(pos1), .step(step1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    logic [95:0] init_msg;
    init_msg = 96'hffffffff20119127ffffffff;
    for (int i = 0; i < N; i++) m_msg[k][i] = init_msg[i*4 +: 4];
    m_pos[k]  = 0;
    m_cnt[k]  = 0;
    m_step[k] = 0;
    m_wrap[k] = 0;
  endtask

  task automatic model_edge(input int k);
    bit         tick;
    logic [3:0] lost;
    if (rst) begin
      model_reset(k);
    end else if (load) begin
      for (int i = 0; i < N; i++) m_msg[k][i] = load_data[i*4 +: 4];
      m_pos[k]  = 0;
      m_cnt[k]  = 0;
      m_step[k] = 0;
      m_wrap[k] = 0;
    end else begin
      tick = en && (m_cnt[k] == div_of[k] - 1);
      if (en) m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
      if (tick) begin
        if (!dir) begin
          lost = m_msg[k][0];
          for (int i = 0; i < N - 1; i++) m_msg[k][i] = m_msg[k][i+1];
          m_msg[k][N-1] = mode ? fill : lost;
          m_pos[k] = (m_pos[k] + 1) % N;
        end else begin
          lost = m_msg[k][N-1];
          for (int i = N - 1; i > 0; i--) m_msg[k][i] = m_msg[k][i-1];
          m_msg[k][0] = mode ? fill : lost;
          m_pos[k] = (m_pos[k] + N - 1) % N;
        end
      end
      m_step[k] = tick;
      m_wrap[k] = tick && (m_pos[k] == 0);
    end
  endtask

  function automatic logic [31:0] model_out(input int k);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = m_msg[k][i];
    return r;
  endfunction

  task automatic compare_all();
    chk("out_div1",  out0,  model_out(0));
    chk("pos_div1",  pos0,  m_pos[0]);
    chk("step_div1", step0, m_step[0]);
    chk("wrap_div1", wrap0, m_wrap[0]);
    chk("out_div4",  out1,  model_out(1));
    chk("pos_div4",  pos1,  m_pos[1]);
    chk("step_div4", step1, m_step[1]);
    chk("wrap_div4", wrap1, m_wrap[1]);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  // Called just after an edge: async reset is checked before the next edge.
  task automatic do_rst();
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    compare_all();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] snap_out;
    int          snap_pos;
    int          cnt_steps;

    div_of[0] = 1;
    div_of[1] = 4;
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; fill = 4'h0;
    load = 1'b0; load_data = '0;
    model_reset(0);
    model_reset(1);
    #12;
    compare_all();
    chk("reset_out", out0, 32'hffffffff);
    chk("reset_pos", pos0, 0);

    // Right rotate over the full message
    rst = 1'b0; en = 1'b1;
    cyc();
    chk("rot_1_out", out0, 32'h7fffffff);
    chk("rot_1_pos", pos0, 1);
    repeat (7) cyc();
    chk("rot_8_out", out0, 32'h20119127);
    repeat (16) cyc();
    chk("rot_24_out",  out0,  32'hffffffff);
    chk("rot_24_pos",  pos0,  0);
    chk("rot_24_wrap", wrap0, 1);
    en = 1'b0;
    cyc();
    chk("wrap_one_cycle", wrap0, 0);

    // Load then one left rotate
    load = 1'b1; load_data = 96'h0123456789abcdef01234567;
    cyc();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    cyc();
    en = 1'b0;
    chk("left_out",  out0,  32'h12345670);
    chk("left_pos",  pos0,  23);
    chk("left_wrap", wrap0, 0);

    // Fill mode, right shift
    do_rst();
    dir = 1'b0; mode = 1'b1; fill = 4'h0; en = 1'b1;
    repeat (8) cyc();
    chk("fill_8_out", out0, 32'h20119127);
    repeat (16) cyc();
    chk("fill_24_out", out0, 32'h00000000);

    // DIV=4 cadence, freeze, resume
    en = 1'b0; mode = 1'b0;
    do_rst();
    en = 1'b1;
    cnt_steps = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step1) cnt_steps++;
    end
    chk("div4_step_count", cnt_steps, 5);
    repeat (2) cyc();
    en = 1'b0;
    snap_out = model_out(1);
    snap_pos = m_pos[1];
    repeat (10) cyc();
    chk("freeze_out", out1, snap_out);
    chk("freeze_pos", pos1, snap_pos);
    chk("freeze_step", step1, 0);
    en = 1'b1;
    cyc();
    chk("resume_no_step_yet", step1, 0);
    cyc();
    chk("resume_step", step1, 1);

    // Load coinciding with a tick
    load = 1'b1; load_data = 96'hfedcba9876543210deadbeef;
    cyc();
    load = 1'b0;
    chk("load_tick_out",  out0,  32'hdeadbeef);
    chk("load_tick_pos",  pos0,  0);
    chk("load_tick_step", step0, 0);

    // Reset mid-count, observed before the next edge
    repeat (6) cyc();
    rst = 1'b1;
    #2;
    chk("async_rst_out_div4", out1, 32'hffffffff);
    chk("async_rst_out_div1", out0, 32'hffffffff);
    model_reset(0);
    model_reset(1);
    cyc();
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 9) < 7);
      dir       = $urandom_range(0, 1);
      mode      = $urandom_range(0, 1);
      fill      = 4'($urandom);
      load      = ($urandom_range(0, 19) == 0);
      load_data = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 99) == 0) do_rst();
      else cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
